// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Groups the request bus (fields + valid/ready), the instruction-memory
// write port and the status outputs of instr_encoder.
//   slave  modport : used by the encoder itself
//   master modport : used by whatever drives requests and models memory
// Ports (per signal): clear, in_valid, in_ready, in_kind, in_funct3,
// in_funct7, in_rd, in_rs1, in_rs2, in_imm, mem_we, mem_ready, mem_addr,
// mem_wdata, count, full.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [11:0]       in_imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;

  modport slave (
    input  clear, in_valid, in_kind, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full
  );

  modport master (
    output clear, in_valid, in_kind, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
// Turns RISC-V instruction requests (I-type ALU, R-type ALU, LW, SW) given
// as separate fields into 32-bit instruction words and writes them to
// consecutive instruction-memory word addresses, starting at 0. Used to
// load a program before the core leaves reset.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : instr_encoder_if.slave -- request fields with valid/ready,
//           memory write port (mem_we/mem_ready/mem_addr/mem_wdata),
//           synchronous clear, word count and full flag.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic last;
  logic in_ready;
  logic accept;
  logic write_done;

  // Build the instruction word from the request fields. Shift-immediates
  // (funct3 001/101) carry funct7 in the upper immediate bits; loads and
  // stores force funct3 to the word width regardless of the request.
  function automatic logic [31:0] encode(
    input logic [1:0]  kind,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [31:0] word;
    word = 32'd0;
    case (kind)
      2'b00: begin
        if (f3 == 3'b001 || f3 == 3'b101)
          word = {f7, imm[4:0], rs1, f3, rd, OP_IMM};
        else
          word = {imm, rs1, f3, rd, OP_IMM};
      end
      2'b01:   word = {f7, rs2, rs1, f3, rd, OP_REG};
      2'b10:   word = {imm, rs1, F3_WORD, rd, OP_LOAD};
      default: word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
    endcase
    return word;
  endfunction

  // A pending write to the top address must not be overlapped by another
  // request: there is no address left for it.
  assign last       = (addr_q == LAST_ADDR);
  assign in_ready   = (state_q == EMPTY) |
                      ((state_q == HOLD) & bus.mem_ready & ~last);
  assign accept     = bus.in_valid & in_ready & ~bus.clear;
  assign write_done = (state_q == HOLD) & bus.mem_ready;

  // Next-state logic. addr_q is the address of the pending write while in
  // HOLD and the address the next request will use while in EMPTY, so it
  // only moves when a write completes. It stops at the top address instead
  // of wrapping. clear overrides everything, including a completing write.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;

    if (bus.clear) begin
      state_d = EMPTY;
      addr_d  = '0;
      count_d = '0;
    end else begin
      if (write_done) begin
        count_d = count_q + (ADDR_W+1)'(1);
        if (!last)
          addr_d = addr_q + ADDR_W'(1);
      end

      if (accept) begin
        wdata_d = encode(bus.in_kind, bus.in_funct3, bus.in_funct7,
                         bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        state_d = HOLD;
      end else if (write_done) begin
        state_d = last ? FULL : EMPTY;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = (state_q == HOLD);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = (state_q == FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed bench for instr_encoder built with ADDR_W=2 so the fill/full
// behaviour is reached quickly. Each accepted request pushes its expected
// {address, word} onto a scoreboard queue; the head is compared against the
// memory port while pending and popped when the write completes.
module tb_instr_encoder;

  localparam int AW = 2;
  localparam logic [AW-1:0] MAXA = {AW{1'b1}};

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } sb_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sb_t           sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW:0]   m_count;
  logic          m_full;
  logic [AW-1:0] m_next;
  logic [31:0]   cur_word;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    m_count = '0;
    m_full  = 1'b0;
    m_next  = '0;
  endtask

  // Drive one request onto the bus together with its expected encoding.
  task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [11:0] imm, input logic [31:0] word);
    bus.in_valid  = 1'b1;
    bus.in_kind   = kind;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    cur_word      = word;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock: check combinational outputs and the pending write at the
  // falling edge, update the model for the coming rising edge, then check
  // the registered status just after it.
  task automatic cycle();
    logic exp_ready;
    logic done;
    logic acc;
    logic was_last;
    sb_t  e;
    @(negedge clk);
    exp_ready = !m_full &&
                (sb.size() == 0 || (bus.mem_ready && sb[0].addr != MAXA));
    checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    checkOutput("mem_we", {31'd0, bus.mem_we}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      checkOutput("mem_addr", {30'd0, bus.mem_addr}, {30'd0, sb[0].addr});
      checkOutput("mem_wdata", bus.mem_wdata, sb[0].word);
    end
    if (bus.clear) begin
      modelReset();
    end else begin
      done = (sb.size() != 0) && bus.mem_ready;
      acc  = bus.in_valid && exp_ready;
      if (done) begin
        was_last = (sb[0].addr == MAXA);
        void'(sb.pop_front());
        m_count++;
        if (was_last && !acc)
          m_full = 1'b1;
      end
      if (acc) begin
        e.addr = m_next;
        e.word = cur_word;
        sb.push_back(e);
        m_next++;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("count", {29'd0, bus.count}, {29'd0, m_count});
    checkOutput("full", {31'd0, bus.full}, {31'd0, m_full});
  endtask

  initial begin
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = 2'b00;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_imm    = 12'd0;
    bus.mem_ready = 1'b1;
    cur_word      = 32'd0;
    modelReset();

    #1;
    $display("[TB] reset values");
    checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {30'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("rst_count", {29'd0, bus.count}, 32'd0);
    checkOutput("rst_full", {31'd0, bus.full}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] single addi");
    applyStimulus(2'b00, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5, 32'h00500093);
    cycle();
    idle();
    cycle();
    cycle();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;

    $display("[TB] back-to-back R/I requests filling memory");
    applyStimulus(2'b01, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 12'd0, 32'h002081B3);
    cycle();
    applyStimulus(2'b00, 3'b101, 7'b0100000, 5'd4, 5'd1, 5'd0, 12'd3, 32'h4030D213);
    cycle();
    applyStimulus(2'b01, 3'b110, 7'd0, 5'd7, 5'd6, 5'd5, 12'd0, 32'h005363B3);
    cycle();
    applyStimulus(2'b00, 3'b001, 7'd0, 5'd1, 5'd2, 5'd0, 12'd31, 32'h01F11093);
    cycle();
    cycle();
    cycle();
    idle();
    cycle();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;

    $display("[TB] loads, stores and ignored funct fields");
    applyStimulus(2'b10, 3'b111, 7'h7F, 5'd5, 5'd2, 5'd9, 12'd8, 32'h00812283);
    cycle();
    applyStimulus(2'b11, 3'b111, 7'h7F, 5'd17, 5'd2, 5'd5, 12'd12, 32'h00512623);
    cycle();
    applyStimulus(2'b00, 3'b000, 7'h7F, 5'd10, 5'd11, 5'd0, 12'hFFF, 32'hFFF58513);
    cycle();
    applyStimulus(2'b11, 3'b111, 7'd0, 5'd0, 5'd1, 5'd31, 12'hFFC, 32'hFFF0AE23);
    cycle();
    applyStimulus(2'b10, 3'b010, 7'd0, 5'd6, 5'd0, 5'd0, 12'd4, 32'h00402303);
    cycle();
    cycle();
    cycle();
    idle();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    applyStimulus(2'b00, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5, 32'h00500093);
    cycle();
    idle();
    cycle();
    cycle();

    $display("[TB] backpressure");
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    applyStimulus(2'b01, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 12'd0, 32'h002081B3);
    cycle();
    bus.mem_ready = 1'b0;
    applyStimulus(2'b10, 3'b111, 7'd0, 5'd5, 5'd2, 5'd0, 12'd8, 32'h00812283);
    cycle();
    cycle();
    cycle();
    bus.mem_ready = 1'b1;
    cycle();
    idle();
    cycle();
    cycle();

    $display("[TB] reset during pending write");
    applyStimulus(2'b00, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5, 32'h00500093);
    cycle();
    bus.mem_ready = 1'b0;
    idle();
    cycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("arst_count", {29'd0, bus.count}, 32'd0);
    checkOutput("arst_mem_addr", {30'd0, bus.mem_addr}, 32'd0);
    checkOutput("arst_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    modelReset();
    bus.mem_ready = 1'b1;

    $display("[TB] clear and accept on the same edge");
    applyStimulus(2'b00, 3'b101, 7'b0100000, 5'd4, 5'd1, 5'd0, 12'd3, 32'h4030D213);
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    idle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes RISC-V instruction requests (I-type ALU, R-type ALU, LW, SW) from separate fields into 32-bit instruction words. Writes the words to sequential instruction-memory addresses. It runs in the opposite direction to the single-cycle processor's opcode decoder: the decoder turns opcodes into control signals, and this block turns fields into opcodes and full instruction words. It sits between a test or boot source and the instruction-memory write port, and it loads programs before the core is released from reset.

## Interface
- ADDR_W, 6: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous restart: address and count return to 0, and any pending write is dropped.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_kind  in  2  request type: 00 I-type ALU, 01 R-type, 10 LW, 11 SW.
- in_funct3  in  3  funct3. Ignored for LW and SW.
- in_funct7  in  7  funct7. Used for R-type, and for I-type shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  12  immediate.
- mem_we  out  1  write request to instruction memory.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address of the pending write.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written since reset or clear.
- full  out  1  memory has been completely loaded.

## Operation
- The FSM has three states: EMPTY, HOLD and FULL.
- Accept: a request is accepted on a rising edge where in_valid & in_ready & !clear. The encoded word is registered into mem_wdata, mem_addr takes the next address, and the state becomes HOLD.
- in_ready is a combinational signal: (state==EMPTY) | (state==HOLD & mem_ready & !last).
  - last means the pending write goes to address 2^ADDR_W−1.
- Write completes on an edge where mem_we & mem_ready. On that edge:
  - count increments and the address increments.
  - If a new request is accepted on the same edge, the state stays HOLD with the new word.
  - Otherwise, if the write was last, the state goes to FULL.
  - Otherwise the state goes to EMPTY.
- mem_we equals (state==HOLD).
- FULL: in_ready=0 and full=1. Only clear or reset leave FULL. The address never wraps.
- clear has priority over everything else. It sets state=EMPTY, count=0, mem_addr=0 and mem_we=0, and the pending write is lost.
- Encoding, with fields listed from bit 31 down to bit 0:
  - I-type: imm[11:0], rs1, funct3, rd, 0010011.
    - If funct3 is 001 or 101 (shift), bits [31:25] come from funct7 and bits [24:20] from imm[4:0].
  - R-type: funct7, rs2, rs1, funct3, rd, 0110011.
  - LW: imm[11:0], rs1, 010, rd, 0000011.
  - SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
- Fields are used verbatim. There is no range checking, and rd=x0 is legal.

## Timing
- Reset values: state=EMPTY, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0. in_ready reads 1 once reset is asserted.
- Latency: a request accepted at edge N appears on mem_we, mem_addr and mem_wdata in the cycle after edge N.
- Throughput is one word per cycle while mem_ready stays high. No bubble is inserted between back-to-back requests.
- While mem_we=1 and mem_ready=0, mem_addr and mem_wdata hold stable and in_ready=0.
- count updates on the same edge as the write completion.
- full asserts in the cycle after the last write completes.
- Reset asserted mid-write forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Single I-type request addi x1,x0,5, with mem_ready held at 1:
  - Next cycle: mem_we=1, mem_addr=0, mem_wdata=0x00500093.
  - Following edge: count=1.
- Back-to-back requests with mem_ready=1:
  - add x3,x1,x2 → 0x002081B3 at address 0.
  - srai x4,x1,3 (funct7=0100000) → 0x4030D213 at address 1.
  - One word per cycle.
- LW and SW requests:
  - lw x5,8(x2) → 0x00812283.
  - sw x5,12(x2) → 0x00512623.
  - Both must be correct even when in_funct3 is driven to 111.
- Backpressure: hold mem_ready=0 for 3 cycles on a pending write.
  - mem_we, mem_addr and mem_wdata stay stable.
  - in_ready=0 and count does not change.
  - The write completes on the first edge with mem_ready=1.
- Fill with ADDR_W=2:
  - After 4 writes: full=1, count=4, in_ready=0. Further in_valid is ignored.
  - clear then gives count=0, full=0, in_ready=1, and the next write goes to address 0.
- Reset while a write is pending (mem_ready=0):
  - mem_we drops asynchronously and count returns to 0.
  - clear and accept on the same edge: the request is dropped and the state is EMPTY.
